coriolis_leaf_share_arb: RTL and testbench
==========================================

Name:
coriolis_leaf_share_arb

Overview:
- Round-robin arbiter that time-shares one 2-operand streaming leaf node (add-type, 1-cycle registered, valid/ready) between NREQ requester streams in the coriolis kernel.
- Each accepted operand pair is tagged with its requester index in an in-flight tag FIFO.
- Leaf results are steered back to the owning requester in issue order.
- Sits between the sub-kernel stream producers and a single shared leaf instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STREAMW, 32, operand/result width.
- TAGW, 2, requester index width; equals clog2(NREQ).
- DEPTH, 4, maximum in-flight operations (tag FIFO depth, power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept
- req_in1  in  NREQ*STREAMW  packed operand 1; slice i belongs to requester i
- req_in2  in  NREQ*STREAMW  packed operand 2
- rsp_valid  out  NREQ  one-hot result valid
- rsp_ready  in  NREQ  per-requester result ready
- rsp_data  out  STREAMW  result, broadcast to all requesters
- leaf_ivalid  out  1  to leaf: ivalid_in1 and ivalid_in2, tied together
- leaf_in1  out  STREAMW  to leaf in1
- leaf_in2  out  STREAMW  to leaf in2
- leaf_iready  in  1  from leaf iready
- leaf_ovalid  in  1  from leaf ovalid
- leaf_out  in  STREAMW  from leaf out1
- leaf_oready  out  1  to leaf oready

Behaviour:
- Reset: req_ready=0, rsp_valid=0, leaf_ivalid=0, leaf_oready=0; rr pointer=0; tag FIFO empty; FSM=IDLE.

FSM states:
- IDLE: no request pending or FIFO full. Go to GRANT when any req_valid=1 and FIFO not full.
- GRANT: combinational round-robin pick g, the first valid requester at or after the pointer.
  - Drive leaf_ivalid=1 and leaf_in*=req_in*[g]; req_ready[g]=leaf_iready.
  - Issue fires when leaf_ivalid & leaf_iready. On issue: push g to FIFO, pointer <= g+1 mod NREQ.
  - On issue, stay in GRANT if more work is pending, otherwise go to IDLE.
  - If leaf_iready=0, go to HOLD.
- HOLD: grant locked to g. Operands must not switch during a leaf stall, and newly valid requesters are ignored. On issue, return to GRANT or IDLE.

Issue and response rules:
- Issue is permitted only if the FIFO is not full, or a pop occurs in the same cycle.
- Head tag h = FIFO head. leaf_oready = FIFO non-empty & rsp_ready[h].
- rsp_valid[h] = leaf_ovalid & leaf_oready; all other bits 0. rsp_data = leaf_out.
- A pop fires on leaf_ovalid & leaf_oready.
- Simultaneous push and pop keeps the count unchanged, including when full.

Boundary conditions:
- A leaf_ovalid with an empty FIFO is a protocol error. The arbiter drops it, and the assertion fires in simulation.
- Any single requester may use 100% throughput when it is the only valid requester.
- With all requesters valid, grants rotate 0,1,2,3,0…
- rst mid-operation discards in-flight tags. The leaf is reset by the same rst.
- Latency: operand accept to rsp_valid is the leaf latency, 1 cycle with no stall.

Optional Feature:
- COR_ARB_STATS_EN defined:
  - Adds outputs stat_issue_cnt (32b, count of issues) and stat_stall_cnt (32b, cycles in HOLD plus cycles blocked by a full FIFO).
  - Both counters clear on rst and saturate at all-ones.
- COR_ARB_STATS_EN undefined: these ports and counters do not exist.

Decomposition:
- Package coriolis_arb_pkg:
  - FSM state typedef (IDLE, GRANT, HOLD).
  - Constants for default NREQ, DEPTH and STREAMW.
  - TAGW derivation function.
- Sub-module coriolis_tag_fifo: synchronous FIFO of TAGW entries with depth DEPTH and full/empty flags; push and pop in the same cycle are allowed.

Test Plan:
- Single requester 2 streams 10 pairs (i, 2i), leaf always ready.
  - req_ready[2]=1 every cycle.
  - rsp_valid[2] one cycle after each accept, with rsp_data=3i.
  - No other rsp_valid bits assert.
- All 4 requesters valid continuously.
  - Grant order is 0,1,2,3,0,1,…
  - Each requester receives its own sums in order.
- leaf_iready=0 for 3 cycles during a grant to requester 1 while requester 0 asserts.
  - FSM is in HOLD.
  - leaf_in* stays stable with requester 1 operands.
  - Requester 1 issues first once ready.
- rsp_ready[h]=0 with 4 operations in flight.
  - leaf_oready=0 and the FIFO is full.
  - No further req_ready is asserted.
  - Release gives in-order drain, with issue resuming on the pop cycle.
- rst asserted mid-stream with 2 operations in flight.
  - Next cycle all outputs are 0, the FIFO is empty and the pointer is 0.
  - The first post-reset grant goes to the lowest valid index.
- With COR_ARB_STATS_EN, 8 issues and 3 HOLD cycles give stat_issue_cnt=8 and stat_stall_cnt=3.

Source files
------------

// File: rtl/coriolis_arb_pkg.sv
// Shared types and defaults for the coriolis leaf share arbiter.
// Optional statistics counters are enabled with COR_ARB_STATS_EN.
package coriolis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int COR_NREQ    = 4;
    localparam int COR_DEPTH   = 4;
    localparam int COR_STREAMW = 32;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/coriolis_tag_fifo.sv
// In-flight requester tag FIFO; push and pop may fire in the same cycle.
// A full FIFO still accepts a push when a pop frees the head slot.
module coriolis_tag_fifo
    import coriolis_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = COR_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign head_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coriolis_leaf_share_arb.sv
// Round-robin time-sharing of one 2-operand leaf between NREQ streams.
// Define COR_ARB_STATS_EN to add issue/stall statistics outputs.
module coriolis_leaf_share_arb
    import coriolis_arb_pkg::*;
#(
    parameter int NREQ    = COR_NREQ,
    parameter int STREAMW = COR_STREAMW,
    parameter int TAGW    = tag_width(COR_NREQ),
    parameter int DEPTH   = COR_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*STREAMW-1:0] req_in1,
    input  logic [NREQ*STREAMW-1:0] req_in2,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [STREAMW-1:0]      rsp_data,
    output logic                    leaf_ivalid,
    output logic [STREAMW-1:0]      leaf_in1,
    output logic [STREAMW-1:0]      leaf_in2,
    input  logic                    leaf_iready,
    input  logic                    leaf_ovalid,
    input  logic [STREAMW-1:0]      leaf_out,
    output logic                    leaf_oready
`ifdef COR_ARB_STATS_EN
    ,
    output logic [31:0]             stat_issue_cnt,
    output logic [31:0]             stat_stall_cnt
`endif
);

    localparam logic [TAGW-1:0] LAST = TAGW'(NREQ - 1);

    arb_state_e      state_q;
    logic [TAGW-1:0] ptr_q;
    logic [TAGW-1:0] ptr_d;
    logic [TAGW-1:0] hold_g_q;

    logic [STREAMW-1:0] op1 [NREQ];
    logic [STREAMW-1:0] op2 [NREQ];

    logic [TAGW-1:0] pick;
    logic [TAGW-1:0] cand;
    logic            found;
    logic [TAGW-1:0] g;
    logic [TAGW-1:0] head;
    logic            any_valid;
    logic            full;
    logic            empty;
    logic            pop;
    logic            room;
    logic            active;
    logic            issue;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op1[i] = req_in1[i*STREAMW +: STREAMW];
        assign op2[i] = req_in2[i*STREAMW +: STREAMW];
    end

    // First valid requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        pick  = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = TAGW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign any_valid = |req_valid;
    assign g         = (state_q == HOLD) ? hold_g_q : pick;
    assign pop       = leaf_ovalid & leaf_oready;
    assign room      = ~full | pop;

    assign active = ((state_q == GRANT) & any_valid) |
                    ((state_q == HOLD) & req_valid[hold_g_q]);

    assign leaf_ivalid = active & room;
    assign leaf_in1    = op1[g];
    assign leaf_in2    = op2[g];
    assign issue       = leaf_ivalid & leaf_iready;
    assign ptr_d       = (g == LAST) ? '0 : g + 1'b1;

    always_comb begin
        req_ready    = '0;
        req_ready[g] = issue;
    end

    assign leaf_oready = ~empty & rsp_ready[head];
    assign rsp_data    = leaf_out;

    always_comb begin
        rsp_valid       = '0;
        rsp_valid[head] = pop;
    end

    coriolis_tag_fifo #(
        .W     (TAGW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .din_i   (g),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_g_q <= '0;
        end else begin
            if (issue) begin
                ptr_q <= ptr_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (any_valid && !full) begin
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!any_valid) begin
                        state_q <= IDLE;
                    end else if (leaf_ivalid && !leaf_iready) begin
                        state_q  <= HOLD;
                        hold_g_q <= pick;
                    end
                end
                HOLD: begin
                    // Operands stay locked to hold_g_q until the leaf takes them.
                    if (issue || !req_valid[hold_g_q]) begin
                        state_q <= any_valid ? GRANT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A result with no owner tag would be lost; flag it in simulation.
    assert property (@(posedge clk) disable iff (rst) !(leaf_ovalid && empty));

`ifdef COR_ARB_STATS_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_cyc;

    assign stall_cyc = (state_q == HOLD) |
                       (any_valid & full & ~pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && !(&issue_cnt_q)) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (stall_cyc && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_coriolis_leaf_share_arb.sv
// Directed bench for coriolis_leaf_share_arb with a queued adder leaf model.
// Stats checks are compiled in when COR_ARB_STATS_EN is defined.
module tb_coriolis_leaf_share_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_in1, req_in2;
    logic [W-1:0]   rsp_data, leaf_in1, leaf_in2, leaf_out;
    logic           leaf_ivalid, leaf_iready, leaf_ovalid, leaf_oready;
`ifdef COR_ARB_STATS_EN
    logic [31:0]    stat_issue_cnt, stat_stall_cnt;
`endif

    coriolis_leaf_share_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .leaf_ivalid (leaf_ivalid),
        .leaf_in1    (leaf_in1),
        .leaf_in2    (leaf_in2),
        .leaf_iready (leaf_iready),
        .leaf_ovalid (leaf_ovalid),
        .leaf_out    (leaf_out),
        .leaf_oready (leaf_oready)
`ifdef COR_ARB_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    // Leaf model: registered adder with a small result queue.
    logic [W-1:0] lq [$];
    logic [W-1:0] ltmp;
    logic [W-1:0] lhead = '0;
    int           lcnt = 0;
    logic         stall = 1'b0;

    assign leaf_iready = (lcnt < 6) && !stall;
    assign leaf_ovalid = (lcnt > 0);
    assign leaf_out    = lhead;

    always @(posedge clk) begin
        if (rst) begin
            lq.delete();
        end else begin
            if (leaf_ovalid && leaf_oready) ltmp = lq.pop_front();
            if (leaf_ivalid && leaf_iready) lq.push_back(leaf_in1 + leaf_in2);
        end
        lcnt  <= lq.size();
        lhead <= (lq.size() > 0) ? lq[0] : '0;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Per-requester stream sources and in-order response tracking.
    logic [W-1:0] src1 [N][16];
    logic [W-1:0] src2 [N][16];
    int           n_items [N];
    int           sent [N];
    int           rcv [N];
    int           grants [$];
    logic [N-1:0] prev_acc;
    bit           chk_lat;
    int           cyc, first_acc, last_acc;

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_src();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = (sent[r] < n_items[r]);
            req_in1[r*W +: W] = req_valid[r] ? src1[r][sent[r]] : '0;
            req_in2[r*W +: W] = req_valid[r] ? src2[r][sent[r]] : '0;
        end
    endtask

    task automatic monitor();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        if (chk_lat) chk("rsp_latency", rsp_valid, prev_acc);
        for (int r = 0; r < N; r++) begin
            if (rsp_valid[r] && rsp_ready[r]) begin
                if (rcv[r] < n_items[r])
                    chk($sformatf("rsp_data_r%0d_%0d", r, rcv[r]), rsp_data,
                        src1[r][rcv[r]] + src2[r][rcv[r]]);
                else
                    chk($sformatf("rsp_extra_r%0d", r), rsp_valid, '0);
                rcv[r]++;
            end
            if (acc[r]) begin
                grants.push_back(r);
                sent[r]++;
            end
        end
        if (acc != '0) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        prev_acc = acc;
    endtask

    task automatic cycle_src();
        drive_src();
        #2;
        monitor();
        advance();
    endtask

    function automatic bit all_done();
        for (int r = 0; r < N; r++)
            if (sent[r] != n_items[r] || rcv[r] != n_items[r]) return 0;
        return 1;
    endfunction

    task automatic run_to_done(input string nm, input int budget);
        for (int k = 0; k < budget && !all_done(); k++) cycle_src();
        chk(nm, all_done(), 1);
    endtask

    task automatic clear_src();
        for (int r = 0; r < N; r++) begin
            n_items[r] = 0;
            sent[r]    = 0;
            rcv[r]     = 0;
        end
        grants.delete();
        prev_acc  = '0;
        first_acc = -1;
        last_acc  = -1;
        chk_lat   = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = '1;
        stall     = 1'b0;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] rdy;
        logic [3:0] rsp;
    } vec_t;

    vec_t tbl [14];
    int   idx;

    initial begin
        tbl[0]  = '{4'b0101, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0101, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0101, 4'b0100, 4'b0001};
        tbl[3]  = '{4'b0101, 4'b0001, 4'b0100};
        tbl[4]  = '{4'b1000, 4'b1000, 4'b0001};
        tbl[5]  = '{4'b0110, 4'b0010, 4'b1000};
        tbl[6]  = '{4'b0110, 4'b0100, 4'b0010};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0100};
        tbl[8]  = '{4'b0010, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0010, 4'b0010, 4'b0000};
        tbl[10] = '{4'b1111, 4'b0100, 4'b0010};
        tbl[11] = '{4'b1111, 4'b1000, 4'b0100};
        tbl[12] = '{4'b1111, 4'b0001, 4'b1000};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0001};
        cyc = 0;

        // Reset state and first grant.
        do_reset();
        req_valid = 4'b1111;
        #2;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_leaf_ivalid", leaf_ivalid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_leaf_oready", leaf_oready, 1'b0);
        advance();
        #2;
        chk("rst_first_grant", req_ready, 4'b0001);

        // Round-robin vector table, operands (i+1, 10*(i+1)).
        do_reset();
        for (int r = 0; r < N; r++) begin
            req_in1[r*W +: W] = W'(r + 1);
            req_in2[r*W +: W] = W'(10 * (r + 1));
        end
        for (int k = 0; k < 14; k++) begin
            req_valid = tbl[k].v;
            #2;
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d_rsp", k), rsp_valid, tbl[k].rsp);
            if (tbl[k].rsp != '0) begin
                idx = 0;
                for (int r = 0; r < N; r++) if (tbl[k].rsp[r]) idx = r;
                chk($sformatf("tbl%0d_data", k), rsp_data, W'(11 * (idx + 1)));
            end
            advance();
        end

        // Single requester 2 streams pairs (i, 2i) at full rate.
        do_reset();
        chk_lat    = 1;
        n_items[2] = 10;
        for (int i = 0; i < 10; i++) begin
            src1[2][i] = W'(i);
            src2[2][i] = W'(2 * i);
        end
        run_to_done("single_done", 40);
        chk("single_grants", grants.size(), 10);
        chk("single_back_to_back", last_acc - first_acc, 9);

        // All four requesters streaming: strict rotation.
        do_reset();
        chk_lat = 1;
        for (int r = 0; r < N; r++) begin
            n_items[r] = 3;
            for (int i = 0; i < 3; i++) begin
                src1[r][i] = W'(r * 1000 + i);
                src2[r][i] = W'(i * 7 + 1);
            end
        end
        run_to_done("rr_done", 60);
        chk("rr_grant_count", grants.size(), 12);
        for (int i = 0; i < grants.size(); i++)
            chk($sformatf("rr_grant%0d", i), grants[i], i % 4);

        // Leaf stall during a grant to requester 1 while requester 0 waits.
        do_reset();
        req_in1[0*W +: W] = 32'd5;
        req_in2[0*W +: W] = 32'd6;
        req_in1[1*W +: W] = 32'h111;
        req_in2[1*W +: W] = 32'h222;
        req_valid = 4'b0001;
        advance();
        #2;
        chk("hold_pre_grant0", req_ready, 4'b0001);
        advance();
        req_valid = 4'b0011;
        stall     = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) req_in1[0*W +: W] = 32'd9;
            #2;
            chk($sformatf("hold%0d_ready", s), req_ready, 4'b0000);
            chk($sformatf("hold%0d_ivalid", s), leaf_ivalid, 1'b1);
            chk($sformatf("hold%0d_in1", s), leaf_in1, 32'h111);
            chk($sformatf("hold%0d_in2", s), leaf_in2, 32'h222);
            advance();
        end
        stall = 1'b0;
        #2;
        chk("hold_release_ready", req_ready, 4'b0010);
        chk("hold_release_in1", leaf_in1, 32'h111);
        advance();
        req_valid = 4'b0001;
        #2;
        chk("hold_next_grant", req_ready, 4'b0001);
        chk("hold_rsp_valid", rsp_valid, 4'b0010);
        chk("hold_rsp_data", rsp_data, 32'h333);
        advance();
        req_valid = 4'b0000;
        #2;
        chk("hold_rsp2_valid", rsp_valid, 4'b0001);
        chk("hold_rsp2_data", rsp_data, 32'd15);
        advance();

        // Response back-pressure fills the tag FIFO, then drains in order.
        do_reset();
        rsp_ready  = 4'b0000;
        n_items[3] = 6;
        for (int i = 0; i < 6; i++) begin
            src1[3][i] = W'(100 + i);
            src2[3][i] = W'(3 * i);
        end
        repeat (5) cycle_src();
        chk("full_issued", grants.size(), 4);
        for (int s = 0; s < 2; s++) begin
            drive_src();
            #2;
            chk($sformatf("full%0d_ready", s), req_ready, 4'b0000);
            chk($sformatf("full%0d_ivalid", s), leaf_ivalid, 1'b0);
            chk($sformatf("full%0d_oready", s), leaf_oready, 1'b0);
            chk($sformatf("full%0d_rsp", s), rsp_valid, 4'b0000);
            monitor();
            advance();
        end
        rsp_ready = 4'b1111;
        drive_src();
        #2;
        chk("drain_pop_rsp", rsp_valid, 4'b1000);
        chk("drain_pop_issue", req_ready, 4'b1000);
        monitor();
        advance();
        run_to_done("drain_done", 40);

        // Reset with two operations in flight.
        do_reset();
        rsp_ready  = 4'b0000;
        n_items[1] = 4;
        for (int i = 0; i < 4; i++) begin
            src1[1][i] = W'(50 + i);
            src2[1][i] = W'(i);
        end
        repeat (3) cycle_src();
        chk("mid_inflight", grants.size(), 2);
        drive_src();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        clear_src();
        rsp_ready = 4'b1111;
        req_valid = 4'b1010;
        #2;
        chk("mid_rst_ready", req_ready, 4'b0000);
        chk("mid_rst_ivalid", leaf_ivalid, 1'b0);
        chk("mid_rst_rsp", rsp_valid, 4'b0000);
        chk("mid_rst_oready", leaf_oready, 1'b0);
        advance();
        #2;
        chk("mid_rst_grant", req_ready, 4'b0010);
        advance();
        req_valid = '0;
        advance();

`ifdef COR_ARB_STATS_EN
        do_reset();
        n_items[0] = 8;
        for (int i = 0; i < 8; i++) begin
            src1[0][i] = W'(i);
            src2[0][i] = W'(i);
        end
        for (int k = 0; k < 40 && !all_done(); k++) begin
            stall = (k >= 3 && k <= 5);
            cycle_src();
        end
        stall = 1'b0;
        chk("stat_done", all_done(), 1);
        advance();
        chk("stat_issue_cnt", stat_issue_cnt, 32'd8);
        chk("stat_stall_cnt", stat_stall_cnt, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
